// File: rtl/out_arb_pkg.sv
// rtl/out_arb_pkg.sv - shared types and helpers for the output stream arbiter
package out_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_OUT_W    = 4;
  localparam int NIB_PER_WORD = DEF_DATA_W / DEF_OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [15:0] hdr_encode(input logic [3:0] gid);
    return {12'd0, gid};
  endfunction

  // Returns {valid, gid}: first requester after ptr, wrapping modulo n.
  function automatic logic [4:0] rr_next(input logic [15:0] req, input logic [3:0] ptr,
                                         input int n);
    logic [4:0] g;
    int idx;
    g = '0;
    for (int k = 16; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[3:0]]) g = {1'b1, idx[3:0]};
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/out_stream_arbiter_if.sv
// rtl/out_stream_arbiter_if.sv - kernel-side ap_fifo style stream bundle
interface out_stream_arbiter_if #(
  parameter int NUM_STREAMS = 4,
  parameter int DATA_W      = 32
);
  logic [NUM_STREAMS*DATA_W-1:0] s_din;
  logic [NUM_STREAMS-1:0]        s_write;
  logic [NUM_STREAMS-1:0]        s_full_n;

  modport master (output s_din, output s_write, input s_full_n);
  modport slave  (input s_din, input s_write, output s_full_n);
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - per-stream elastic buffer with count-based flags
module stream_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full_n,
  output logic              not_empty,
  output logic [DATA_W-1:0] head,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;

  assign full_n    = count < CW'(DEPTH);
  assign not_empty = count != '0;
  assign head      = mem[rd_ptr];
  assign push      = write && full_n;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      // Sticky until reset so a dropped word can never go unnoticed.
      if (write && !full_n) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/out_stream_arbiter.sv
// rtl/out_stream_arbiter.sv - round-robin serializer of kernel streams onto a nibble port
module out_stream_arbiter
  import out_arb_pkg::*;
#(
  parameter int NUM_STREAMS = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  out_stream_arbiter_if.slave    s,
  output logic [OUT_W-1:0]       data_out,
  output logic                   data_valid,
  output logic                   data_last,
  output logic [NUM_STREAMS-1:0] err_overflow,
  output logic [CNT_W-1:0]       frame_cnt
);
  localparam int NIB   = DATA_W / OUT_W;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);

  logic [NUM_STREAMS-1:0] full_n;
  logic [NUM_STREAMS-1:0] not_empty;
  logic [NUM_STREAMS-1:0] pop;
  logic [DATA_W-1:0]      head [NUM_STREAMS];
  logic [DATA_W-1:0]      head_sel;
  logic [4:0]             grant;

  state_t            state;
  logic [3:0]        ptr;
  logic [DATA_W-1:0] sr;
  logic [NIB_W-1:0]  nib;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_fifo
    stream_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .write     (s.s_write[i]),
      .din       (s.s_din[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .full_n    (full_n[i]),
      .not_empty (not_empty[i]),
      .head      (head[i]),
      .overflow  (err_overflow[i])
    );
  end

  assign s.s_full_n = full_n;

  // Grant sees only registered buffer counts, so a same-cycle push waits a turn.
  assign grant = rr_next(16'(not_empty), ptr, NUM_STREAMS);

  always_comb begin
    pop      = '0;
    head_sel = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (grant[3:0] == 4'(i)) begin
        head_sel = head[i];
        pop[i]   = (state == ST_IDLE) && grant[4];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= ST_IDLE;
      ptr        <= 4'(NUM_STREAMS - 1);
      sr         <= '0;
      nib        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_out   <= '0;
          data_valid <= 1'b0;
          data_last  <= 1'b0;
          if (grant[4]) begin
            sr         <= head_sel;
            ptr        <= grant[3:0];
            data_out   <= OUT_W'(hdr_encode(grant[3:0]));
            data_valid <= 1'b1;
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          data_out  <= sr[OUT_W-1:0];
          sr        <= sr >> OUT_W;
          nib       <= '0;
          data_last <= (NIB_LAST == '0);
          state     <= ST_DATA;
        end
        ST_DATA: begin
          if (nib == NIB_LAST) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            frame_cnt  <= frame_cnt + CNT_W'(1);
            state      <= ST_IDLE;
          end else begin
            data_out  <= sr[OUT_W-1:0];
            sr        <= sr >> OUT_W;
            nib       <= nib + NIB_W'(1);
            data_last <= (nib + NIB_W'(1) == NIB_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_stream_arbiter.sv
// tb/tb_out_stream_arbiter.sv - directed self-checking bench for out_stream_arbiter
module tb_out_stream_arbiter;

  logic       ap_clk;
  logic       ap_rst;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_last;
  logic [3:0] err_overflow;
  logic [3:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  out_stream_arbiter_if #(.NUM_STREAMS(4), .DATA_W(32)) io ();

  out_stream_arbiter #(.CNT_W(4)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .s            (io),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_last    (data_last),
    .err_overflow (err_overflow),
    .frame_cnt    (frame_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    ap_rst     = 1'b1;
    io.s_write = '0;
    io.s_din   = '0;
    tick();
    tick();
    ap_rst = 1'b0;
  endtask

  task automatic push1(input int i, input logic [31:0] w);
    io.s_din[i*32 +: 32] = w;
    io.s_write[i]        = 1'b1;
    tick();
    io.s_write = '0;
  endtask

  task automatic frame(input logic [3:0] g, input logic [31:0] w, input string tag);
    int n;
    tick();
    n = 0;
    while (!data_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_hdr_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_hdr"}, 32'(data_out), 32'(g));
    for (int k = 0; k < 8; k++) begin
      tick();
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
      check({tag, "_nib"}, 32'(data_out), 32'(w[4*k +: 4]));
      check({tag, "_last"}, 32'(data_last), (k == 7) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int v;
    v = 0;
    repeat (n) begin
      tick();
      if (data_valid || data_out != 4'd0) v++;
    end
    check(tag, 32'(v), 32'd0);
  endtask

  task automatic wait_last(input string tag);
    int n;
    n = 0;
    while (!data_last && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(data_last), 32'd1);
  endtask

  initial begin
    int start;
    ap_rst     = 1'b1;
    io.s_write = '0;
    io.s_din   = '0;

    // Reset state and a single frame from stream 0
    do_reset();
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_out", 32'(data_out), 32'd0);
    check("rst_last", 32'(data_last), 32'd0);
    check("rst_full_n", 32'(io.s_full_n), 32'hF);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    push1(0, 32'h89ABCDEF);
    check("t1_idle_bubble", 32'(data_valid), 32'd0);
    frame(4'h0, 32'h89ABCDEF, "t1");
    tick();
    check("t1_cnt", 32'(frame_cnt), 32'd1);

    // Four simultaneous writes, then wrap order from ptr=3
    do_reset();
    start = cyc;
    io.s_din   = {32'd3, 32'd2, 32'd1, 32'd0};
    io.s_write = 4'hF;
    tick();
    io.s_write = '0;
    frame(4'h0, 32'd0, "t2_f0");
    frame(4'h1, 32'd1, "t2_f1");
    frame(4'h2, 32'd2, "t2_f2");
    frame(4'h3, 32'd3, "t2_f3");
    check("t2_cycles", 32'(cyc - start), 32'd40);
    io.s_din[0 +: 32]  = 32'h000000A5;
    io.s_din[64 +: 32] = 32'h0000005A;
    io.s_write         = 4'b0101;
    tick();
    io.s_write = '0;
    frame(4'h0, 32'h000000A5, "t2_wrap0");
    frame(4'h2, 32'h0000005A, "t2_wrap2");

    // Fill stream 1 while stream 0 is on the wire, then overflow it
    do_reset();
    push1(0, 32'h00000077);
    tick();
    check("t3_busy_hdr", 32'(data_valid), 32'd1);
    push1(1, 32'h11110000);
    push1(1, 32'h11110001);
    push1(1, 32'h11110002);
    check("t3_full_n_3", 32'(io.s_full_n[1]), 32'd1);
    push1(1, 32'h11110003);
    check("t3_full_n_4", 32'(io.s_full_n[1]), 32'd0);
    check("t3_err_before", 32'(err_overflow), 32'd0);
    push1(1, 32'hDEADDEAD);
    check("t3_err_after", 32'(err_overflow), 32'h2);
    check("t3_full_n_5", 32'(io.s_full_n[1]), 32'd0);
    wait_last("t3_s0_end");
    frame(4'h1, 32'h11110000, "t3_f0");
    frame(4'h1, 32'h11110001, "t3_f1");
    frame(4'h1, 32'h11110002, "t3_f2");
    frame(4'h1, 32'h11110003, "t3_f3");
    quiet(30, "t3_no_extra");
    check("t3_cnt", 32'(frame_cnt), 32'd5);

    // Same-cycle push and pop leaves the count unchanged
    push1(0, 32'h00000099);
    tick();
    push1(2, 32'h22220000);
    push1(2, 32'h22220001);
    push1(2, 32'h22220002);
    wait_last("t4_s0_end");
    tick();
    check("t4_idle", 32'(data_valid), 32'd0);
    push1(2, 32'h22220003);
    check("t4_hdr_valid", 32'(data_valid), 32'd1);
    check("t4_hdr", 32'(data_out), 32'd2);
    check("t4_full_n_pp", 32'(io.s_full_n[2]), 32'd1);
    push1(2, 32'h22220004);
    check("t4_full_n_4", 32'(io.s_full_n[2]), 32'd0);
    check("t4_err", 32'(err_overflow), 32'h2);

    // Reset during the fourth data nibble
    do_reset();
    push1(0, 32'h12345678);
    push1(1, 32'hCAFEF00D);
    check("t5_hdr", 32'(data_out), 32'd0);
    check("t5_hdr_valid", 32'(data_valid), 32'd1);
    repeat (4) tick();
    check("t5_nib4", 32'(data_out), 32'h5);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("t5_valid", 32'(data_valid), 32'd0);
    check("t5_out", 32'(data_out), 32'd0);
    check("t5_cnt", 32'(frame_cnt), 32'd0);
    check("t5_full_n", 32'(io.s_full_n), 32'hF);
    check("t5_err", 32'(err_overflow), 32'd0);
    quiet(30, "t5_no_nibbles");

    // Frame counter wrap over 2^CNT_W + 1 frames from stream 3
    do_reset();
    for (int f = 0; f < 17; f++) begin
      push1(3, 32'hF00D0000 | 32'(f));
      frame(4'h3, 32'hF00D0000 | 32'(f), "t6");
    end
    tick();
    check("t6_cnt_wrap", 32'(frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
